encoder_tachometer: RTL

Measures wheel-encoder pulse period and direction for the RSLK motor control path. It samples the quadrature encoder channels A and B on `sysclk` and counts `sysclk` cycles between accepted rising edges of channel A. It reports the period, direction, stall status and a signed position count to the controller module. It is the measuring counterpart of the clock divider: the divider synthesizes a rate from `sysclk`, and this block recovers a rate in `sysclk` cycles.

---
 rtl/encoder_tachometer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/encoder_tachometer.sv
// Quadrature encoder tachometer: A-rise period, direction, stall, position.
// Ports: sysclk, rst_n, enable, enc_a, enc_b -> period, period_valid, dir, stalled, position.
module encoder_tachometer #(
  parameter int CNT_W      = 24,
  parameter int POS_W      = 16,
  parameter int MIN_PERIOD = 120,
  parameter int TIMEOUT    = 12_000_000
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             dir,
  output logic             stalled,
  output logic [POS_W-1:0] position
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_s1, a_s2, a_s3;
  logic b_s1, b_s2;
  logic a_rise;

  logic first;
  logic accept;
  logic stall;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      a_s3 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      a_s3 <= a_s2;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
    end
  end

  assign a_rise = a_s2 & ~a_s3;

  // A rise on the timeout cycle is accepted because the
  // accept branch is tested before the timeout branch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first   = 1'b0;
    accept  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && a_rise) begin
          first   = 1'b1;
          cnt_d   = ONE_C;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (a_rise && cnt_q >= MIN_C) begin
          accept = 1'b1;
          cnt_d  = ONE_C;
        end else if (cnt_q == TO_C) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      dir          <= 1'b0;
      stalled      <= 1'b0;
      position     <= '0;
    end else begin
      period_valid <= accept | stall;
      if (accept) begin
        period  <= cnt_q;
        stalled <= 1'b0;
      end
      if (stall) begin
        period  <= '1;
        stalled <= 1'b1;
      end
      // B low at the A rise means forward.
      if (accept || first) begin
        dir      <= ~b_s2;
        position <= b_s2 ? position - POS_W'(1)
                         : position + POS_W'(1);
      end
    end
  end

endmodule
